// File: rtl/cmd_uart_tx.sv
// Sends the controller's command code as one ASCII byte over an 8N1 UART line,
// on every command change and periodically as a keep-alive.
module cmd_uart_tx #(
    parameter int unsigned CLKS_PER_BIT  = 5208,
    parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] c_s,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [2:0]        CODE_NONE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        cs_meta;
    logic [2:0]        cs_q;
    logic [1:0]        sync_fill;
    logic [2:0]        last_sent;
    logic [2:0]        last_sent_next;
    logic [7:0]        shreg;
    logic [7:0]        shreg_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_cnt_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_next;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_cnt_next;
    logic              tx_next;
    logic              busy_next;
    logic              frame_done_next;
    logic              bit_end;
    logic              change_trig;
    logic              keepalive_trig;
    logic [2:0]        send_code;

    function automatic logic code_valid(input logic [2:0] code);
        return (code == 3'b000) || (code == 3'b001) || (code == 3'b010);
    endfunction

    function automatic logic [7:0] code_byte(input logic [2:0] code);
        logic [7:0] b;
        case (code)
            3'b000:  b = 8'h53;
            3'b001:  b = 8'h46;
            3'b010:  b = 8'h42;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Two-flop synchroniser; sync_fill marks when cs_q holds a real sample after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_meta   <= 3'b000;
            cs_q      <= 3'b000;
            sync_fill <= 2'b00;
        end else begin
            cs_meta   <= c_s;
            cs_q      <= cs_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            last_sent  <= CODE_NONE;
            shreg      <= 8'h00;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            rep_cnt    <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            last_sent  <= last_sent_next;
            shreg      <= shreg_next;
            baud_cnt   <= baud_cnt_next;
            bit_idx    <= bit_idx_next;
            rep_cnt    <= rep_cnt_next;
            tx         <= tx_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
        end
    end

    always_comb begin
        state_next     = state;
        last_sent_next = last_sent;
        shreg_next     = shreg;
        baud_cnt_next  = baud_cnt;
        bit_idx_next   = bit_idx;
        rep_cnt_next   = rep_cnt;

        bit_end        = (baud_cnt == BAUD_LAST);
        change_trig    = sync_fill[1] && code_valid(cs_q) && (cs_q != last_sent);
        keepalive_trig = code_valid(last_sent) && (rep_cnt == REP_LAST);
        send_code      = change_trig ? cs_q : last_sent;

        case (state)
            S_IDLE: begin
                if (change_trig || keepalive_trig) begin
                    state_next     = S_START;
                    baud_cnt_next  = '0;
                    bit_idx_next   = 3'd0;
                    shreg_next     = code_byte(send_code);
                    last_sent_next = send_code;
                    rep_cnt_next   = '0;
                end else if (code_valid(last_sent)) begin
                    rep_cnt_next = rep_cnt + REP_W'(1);
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next    = S_DATA;
                    baud_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shreg_next   = {1'b0, shreg[7:1]};
                    end
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_W'(1);
                end
            end
            S_STOP: begin
                // A change seen during the frame goes out back-to-back with no idle bit.
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (change_trig) begin
                        state_next     = S_START;
                        bit_idx_next   = 3'd0;
                        shreg_next     = code_byte(cs_q);
                        last_sent_next = cs_q;
                        rep_cnt_next   = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next       = (state_next != S_IDLE);
        frame_done_next = (state_next == S_STOP) && (baud_cnt_next == BAUD_LAST);
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_cmd_uart_tx.sv
// Bench for cmd_uart_tx: frame-level model checked every cycle, plus a line decoder
// whose captured bytes and start times are pinned against hand-computed values.
module tb_cmd_uart_tx;

    localparam int CPB = 4;
    localparam int REP = 200;

    logic       clk;
    logic       rst_n = 1'b0;
    logic [2:0] c_s   = 3'b000;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int tests = 0;
    int fails = 0;
    int ncyc  = 0;

    cmd_uart_tx #(.CLKS_PER_BIT(CPB), .REPEAT_CYCLES(REP)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .c_s        (c_s),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [2:0] code);
        case (code)
            3'b000:  return 8'h53;
            3'b001:  return 8'h46;
            default: return 8'h42;
        endcase
    endfunction

    // Frame-level model: which byte is on the line and since which clock edge.
    logic [2:0] m_s1 = 3'b111, m_s2 = 3'b111, m_last = 3'b111;
    logic [7:0] m_byte = 8'h00;
    bit         m_busy = 1'b0;
    int         m_cyc = 0, m_start = 0, m_idle_since = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = 3'b111; m_s2 = 3'b111; m_last = 3'b111;
                m_busy = 1'b0; m_cyc = 0; m_start = 0; m_idle_since = 0; m_byte = 8'h00;
            end else begin
                bit free;
                bit ka;
                m_cyc++;
                ka   = !m_busy && (m_last <= 3'd2) && (m_cyc - m_idle_since == REP);
                free = !m_busy;
                if (m_busy && (m_cyc - m_start == 10 * CPB)) begin
                    m_busy       = 1'b0;
                    m_idle_since = m_cyc;
                    free         = 1'b1;
                end
                if (free) begin
                    if ((m_s2 <= 3'd2) && (m_s2 != m_last)) begin
                        m_busy = 1'b1; m_start = m_cyc; m_last = m_s2; m_byte = ascii_of(m_s2);
                    end else if (ka) begin
                        m_busy = 1'b1; m_start = m_cyc; m_byte = ascii_of(m_last);
                    end
                end
                m_s2 = m_s1;
                m_s1 = c_s;
            end
        end
    end

    // Line decoder and per-cycle compare, both on the falling edge.
    logic [7:0] dq_b[$];
    int         dq_t[$];
    logic [9:0] dec_bits = '0;
    logic [7:0] dec_byte = '0;
    bit         dec_on = 1'b0;
    int         dec_t0 = 0;
    int         busy_cnt = 0, fd_cnt = 0;

    initial begin
        forever begin
            int j, b, e_tx, e_busy, e_fd, off;
            @(negedge clk);
            ncyc++;
            if (m_busy) begin
                j      = m_cyc - m_start;
                b      = j / CPB;
                e_busy = 1;
                e_fd   = (j == 10 * CPB - 1) ? 1 : 0;
                if (b == 0)      e_tx = 0;
                else if (b <= 8) e_tx = int'((m_byte >> (b - 1)) & 8'h01);
                else             e_tx = 1;
            end else begin
                e_tx = 1; e_busy = 0; e_fd = 0;
            end
            check("tx", int'(tx), e_tx);
            check("busy", int'(busy), e_busy);
            check("frame_done", int'(frame_done), e_fd);
            busy_cnt += int'(busy);
            fd_cnt   += int'(frame_done);

            if (!rst_n) begin
                dec_on = 1'b0;
            end else if (!dec_on) begin
                if (tx == 1'b0) begin
                    dec_on = 1'b1;
                    dec_t0 = ncyc;
                end
            end else begin
                off = ncyc - dec_t0;
                if (off % CPB == CPB / 2) begin
                    b = off / CPB;
                    dec_bits[b] = tx;
                    if (b >= 1 && b <= 8) dec_byte[b-1] = tx;
                end
                if (off == 10 * CPB - 1) begin
                    dec_on = 1'b0;
                    dq_b.push_back(dec_byte);
                    dq_t.push_back(dec_t0);
                end
            end
        end
    end

    function automatic int qb(input int i);
        return (i < dq_b.size()) ? int'(dq_b[i]) : -1;
    endfunction

    function automatic int qt(input int i);
        return (i < dq_t.size()) ? dq_t[i] : -1;
    endfunction

    task automatic clear_log();
        dq_b.delete();
        dq_t.delete();
        busy_cnt = 0;
        fd_cnt   = 0;
    endtask

    task automatic do_reset(input logic [2:0] code);
        @(posedge clk); #2;
        rst_n = 1'b0;
        c_s   = code;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_busy(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #2;
            if (busy) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    initial begin
        int t_chg, s0;
        logic [9:0] exp_seq;

        // Reset, then hold 000: one 'S' frame, bits 0,1,1,0,0,1,0,1,0,1.
        do_reset(3'b000);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        wait_cycles(60);
        exp_seq = 10'b1010100110;
        check("s1_frames", dq_b.size(), 1);
        check("s1_byte", qb(0), 8'h53);
        check("s1_bits", int'(dec_bits), int'(exp_seq));
        check("s1_busy_cycles", busy_cnt, 40);
        check("s1_done_pulses", fd_cnt, 1);

        // Change to 001 with the line idle, then a keep-alive 200 cycles after busy falls.
        clear_log();
        c_s   = 3'b001;
        t_chg = ncyc;
        wait_cycles(300);
        check("s2_frames", dq_b.size(), 2);
        check("s2_byte", qb(0), 8'h46);
        check("s2_latency", qt(0) - t_chg, 4);
        check("s2_ka_byte", qb(1), 8'h46);
        check("s2_ka_gap", qt(1) - qt(0), 240);

        // 001 -> 010 -> 000 within one frame: only 'S' follows, back-to-back.
        do_reset(3'b001);
        wait_busy("s3_wait_busy");
        wait_cycles(8);
        c_s = 3'b010;
        wait_cycles(8);
        c_s = 3'b000;
        wait_cycles(100);
        check("s3_frames", dq_b.size(), 2);
        check("s3_first", qb(0), 8'h46);
        check("s3_second", qb(1), 8'h53);
        check("s3_gap", qt(1) - qt(0), 40);

        // Invalid code after reset: nothing is ever sent.
        do_reset(3'b101);
        wait_cycles(1000);
        check("s4_frames", dq_b.size(), 0);
        check("s4_busy_cycles", busy_cnt, 0);

        // Reset during data bit 3 forces the line idle at once; a clean frame follows.
        do_reset(3'b001);
        wait_busy("s5_wait_busy");
        wait_cycles(17);
        rst_n = 1'b0;
        #1;
        check("s5_tx_async", int'(tx), 1);
        check("s5_busy_async", int'(busy), 0);
        wait_cycles(3);
        rst_n = 1'b1;
        clear_log();
        wait_cycles(60);
        check("s5_frames", dq_b.size(), 1);
        check("s5_byte", qb(0), 8'h46);

        // Change lands on the keep-alive expiry cycle: the new code wins, timer restarts.
        do_reset(3'b000);
        for (int i = 0; i < 100 && dq_t.size() == 0; i++) wait_cycles(1);
        check("s6_first_frame", dq_t.size(), 1);
        s0 = qt(0);
        for (int i = 0; i < 400 && ncyc < s0 + 236; i++) wait_cycles(1);
        c_s = 3'b001;
        wait_cycles(290);
        check("s6_frames", dq_b.size(), 3);
        check("s6_byte0", qb(0), 8'h53);
        check("s6_byte1", qb(1), 8'h46);
        check("s6_start1", qt(1) - s0, 240);
        check("s6_byte2", qb(2), 8'h46);
        check("s6_start2", qt(2) - s0, 480);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmd_uart_tx.md
# cmd_uart_tx

Serialises the 3-bit command code produced by the human-sensor controller (`c_s`: stop / gesture / sound) into one ASCII byte and transmits it over an 8N1 UART line to the Bluetooth module that links to the car.
- A frame is sent whenever the command changes.
- The current command is resent periodically as a keep-alive.
- The block sits directly downstream of the controller, on the same 50 MHz clock, and drives the Bluetooth module's RX pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 5208: clk cycles per UART bit (50 MHz / 9600 baud).
- `REPEAT_CYCLES`, default 5_000_000: idle cycles before the current command is resent (100 ms).

Ports:
- `clk`  input  1  system clock, 50 MHz.
- `reset`  input  1  asynchronous, active-low reset.
- `c_s`  input  3  command code from the controller. 000 = stop, 001 = gesture, 010 = sound; other values are invalid.
- `tx`  output  1  UART line; idles high.
- `busy`  output  1  high while a frame is on the line.
- `frame_done`  output  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- `c_s` passes through a 2-flop synchroniser; its output is `cs_q`.
- Code-to-byte map:
  - 000 → 0x53 ('S')
  - 001 → 0x46 ('F')
  - 010 → 0x42 ('B')
  - 011 and 1xx are ignored; they never start a frame.
- Register `last_sent[2:0]` resets to 3'b111 (invalid), so the first valid code after reset is always sent.
- Trigger conditions:
  - Change trigger: `cs_q` is valid and `cs_q != last_sent`.
  - Keep-alive trigger: `rep_cnt` reaches `REPEAT_CYCLES-1` while in IDLE and `last_sent` is valid. This resends `last_sent`.
- If both triggers occur in the same cycle, the change trigger wins and `rep_cnt` clears.
- `rep_cnt` counts only in IDLE and clears on every frame start. It does not count while `last_sent` is invalid.
- Frame start: the byte and the code are latched, and `last_sent` is updated with that code on the same cycle.
- FSM states and transitions:
  - IDLE → START on a trigger.
  - START → DATA after one bit time.
  - DATA → STOP after 8 bit times.
  - STOP → IDLE after one bit time.
- Line values per state:
  - IDLE: `tx` = 1.
  - START: `tx` = 0.
  - DATA: `tx` = shift-register LSB, LSB first; the register shifts right at each bit boundary.
  - STOP: `tx` = 1.
- Counters: `baud_cnt` counts 0..`CLKS_PER_BIT`-1; `bit_idx` is 3 bits and counts 0..7 in DATA.
- Changes during a frame are not queued. A frame is never aborted. After STOP, IDLE re-evaluates `cs_q` against `last_sent`, so only the latest code is sent; intermediate codes are dropped.
- An invalid `cs_q` while `last_sent` is valid: no change trigger fires, and keep-alive continues resending `last_sent`.

## Timing
- Reset values:
  - `tx` = 1, `busy` = 0, `frame_done` = 0
  - state = IDLE, `last_sent` = 3'b111
  - all counters = 0, synchroniser = 000
- Reset is asynchronous. Asserting it mid-frame forces `tx` = 1 within the same cycle; no partial frame resumes afterwards.
- Latency: `c_s` changes before edge E; `cs_q` is valid after edge E+1; the trigger is registered at edge E+2. `tx` falls and `busy` rises at edge E+2, i.e. 2 cycles.
- `tx` and `busy` are registered outputs.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles with `busy` high. `busy` falls on the cycle after the `frame_done` pulse.
- Back-to-back frames: a pending change starts a new frame at the edge after `frame_done`. The line has no extra idle bit.
- Keep-alive spacing: a resend starts `REPEAT_CYCLES` cycles after the previous frame's `busy` falls.

## Test plan
Use `CLKS_PER_BIT`=4 and `REPEAT_CYCLES`=200 for all scenarios.
- **Reset, then hold `c_s`=000:** one frame of 0x53. `tx` bit sequence: 0,1,1,0,0,1,0,1,0,1, each held 4 cycles. `frame_done` pulses once; `busy` is high for 40 cycles.
- **Change 000→001 with the line idle:** `tx` falls 2 cycles after the change and carries 0x46. The next frame is a keep-alive 0x46 exactly 200 cycles after `busy` falls.
- **`c_s` 001→010→000 within one frame:** the current frame completes unaltered; the next frame starts the cycle after `frame_done` and carries 0x53 only. 0x42 is never sent.
- **`c_s`=3'b101 after reset:** `tx` stays 1 and `busy` stays 0 for 1000 cycles; no keep-alive fires.
- **Reset asserted at bit 4 of a frame:** `tx` = 1 and `busy` = 0 immediately. After release with `c_s`=001, one full 0x46 frame follows.
- **Change trigger and keep-alive expiry on the same cycle:** exactly one frame, carrying the new code, and `rep_cnt` restarts from 0.
